// File: rtl/common.sv
// Shared types for the machine-mode trap path: CSR command encoding,
// interrupt cause numbers and trap sequencer states.
package common;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ERROR = 2'd1,
        MRET  = 2'd2
    } state_csr;

    localparam int IRQ_MEI = 11;
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT,
        REDIRECT
    } trap_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for enabled M-mode interrupts: MEI > MSI > MTI.
// Produces the full mcause value with the interrupt bit set.
module irq_prio_enc
    import common::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] int_pend,
    output logic            valid,
    output logic [XLEN-1:0] cause
);

    // Only the three M-mode lines can ever be pending here.
    logic unused_pend;
    assign unused_pend = ^int_pend;

    always_comb begin
        valid           = 1'b1;
        cause           = '0;
        cause[XLEN-1]   = 1'b1;
        if (int_pend[IRQ_MEI])      cause[5:0] = 6'(IRQ_MEI);
        else if (int_pend[IRQ_MSI]) cause[5:0] = 6'(IRQ_MSI);
        else if (int_pend[IRQ_MTI]) cause[5:0] = 6'(IRQ_MTI);
        else begin
            valid = 1'b0;
            cause = '0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, MRET and M-mode interrupts, drains the
// pipe, issues one CSR command and redirects fetch. TRAP_CTRL_VECTORED_EN enables mtvec vectored mode.
module trap_ctrl
    import common::*;
#(
    parameter int XLEN          = 64,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_exc,
    input  logic [XLEN-1:0] commit_exc_code,
    input  logic            commit_mret,
    input  logic [XLEN-1:0] next_pc,
    input  logic            pipe_empty,
    input  logic            irq_mei,
    input  logic            irq_msi,
    input  logic            irq_mti,
    input  logic            csr_mstatus_mie,
    input  logic [XLEN-1:0] csr_mie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic [1:0]      mode,
    output state_csr        csr_st,
    output logic            csr_en,
    output logic [XLEN-1:0] csr_pc,
    output logic [XLEN-1:0] csr_code,
    output logic [XLEN-1:0] mip_out,
    output logic            stall_fetch,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

    localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

    trap_state_t     state;
    logic [CW-1:0]   drain_cnt;
    logic [XLEN-1:0] mip_d, int_pend, irq_cause, tgt;
    logic            irq_valid, int_ok, take_exc, take_mret, drain_done;

    always_comb begin
        mip_d          = '0;
        mip_d[IRQ_MEI] = irq_mei;
        mip_d[IRQ_MSI] = irq_msi;
        mip_d[IRQ_MTI] = irq_mti;
    end

    assign int_ok     = (mode != 2'd3) || csr_mstatus_mie;
    assign int_pend   = mip_out & csr_mie;
    assign take_exc   = commit_valid & commit_exc;
    assign take_mret  = commit_valid & commit_mret & ~commit_exc;
    assign drain_done = pipe_empty || ((DRAIN_TIMEOUT != 0) && (drain_cnt == TO_LAST));

    irq_prio_enc #(.XLEN(XLEN)) u_prio (
        .int_pend (int_pend),
        .valid    (irq_valid),
        .cause    (irq_cause)
    );

    // Trap target; csr_code[XLEN-1] doubles as the "this trap is an interrupt" flag.
`ifdef TRAP_CTRL_VECTORED_EN
    always_comb begin
        tgt = csr_mtvec & ~XLEN'(3);
        if (csr_mtvec[1:0] == 2'b01 && csr_code[XLEN-1])
            tgt = tgt + XLEN'({csr_code[5:0], 2'b00});
    end
`else
    assign tgt = csr_mtvec & ~XLEN'(3);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            drain_cnt      <= '0;
            mip_out        <= '0;
            csr_st         <= NONE;
            csr_en         <= 1'b0;
            csr_pc         <= '0;
            csr_code       <= '0;
            stall_fetch    <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            mip_out <= mip_d;
            flush   <= 1'b0;
            csr_en  <= 1'b0;
            csr_st  <= NONE;
            case (state)
                IDLE, DRAIN: begin
                    // A retiring exception/MRET always wins, even over a draining interrupt.
                    if (take_exc) begin
                        csr_pc      <= commit_pc;
                        csr_code    <= commit_exc_code;
                        csr_st      <= ERROR;
                        csr_en      <= 1'b1;
                        flush       <= 1'b1;
                        stall_fetch <= 1'b1;
                        state       <= COMMIT;
                    end else if (take_mret) begin
                        csr_st      <= MRET;
                        csr_en      <= 1'b1;
                        flush       <= 1'b1;
                        stall_fetch <= 1'b1;
                        state       <= COMMIT;
                    end else if (state == IDLE) begin
                        if (int_ok && irq_valid) begin
                            csr_code    <= irq_cause;
                            drain_cnt   <= '0;
                            stall_fetch <= 1'b1;
                            state       <= DRAIN;
                        end
                    end else if (drain_done) begin
                        csr_pc <= next_pc;
                        csr_st <= ERROR;
                        csr_en <= 1'b1;
                        flush  <= 1'b1;
                        state  <= COMMIT;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                COMMIT: begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= (csr_st == MRET) ? csr_mepc : tgt;
                    state          <= REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        stall_fetch    <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR commands and
// redirect targets; a negedge monitor pops and compares them as the DUT emits them.
module tb_trap_ctrl;
    import common::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            commit_valid = 1'b0;
    logic [63:0]     commit_pc = '0;
    logic            commit_exc = 1'b0;
    logic [63:0]     commit_exc_code = '0;
    logic            commit_mret = 1'b0;
    logic [63:0]     next_pc = '0;
    logic            pipe_empty = 1'b1;
    logic            irq_mei = 1'b0, irq_msi = 1'b0, irq_mti = 1'b0;
    logic            csr_mstatus_mie = 1'b1;
    logic [63:0]     csr_mie = '0;
    logic [63:0]     csr_mtvec = 64'h8000_0100;
    logic [63:0]     csr_mepc = '0;
    logic [1:0]      mode = 2'd3;
    state_csr        csr_st;
    logic            csr_en;
    logic [63:0]     csr_pc, csr_code, mip_out, redirect_pc;
    logic            stall_fetch, flush, redirect_valid;
    logic            redirect_ready = 1'b1;

    trap_ctrl #(.XLEN(64), .DRAIN_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_exc(commit_exc),
        .commit_exc_code(commit_exc_code), .commit_mret(commit_mret),
        .next_pc(next_pc), .pipe_empty(pipe_empty),
        .irq_mei(irq_mei), .irq_msi(irq_msi), .irq_mti(irq_mti),
        .csr_mstatus_mie(csr_mstatus_mie), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec),
        .csr_mepc(csr_mepc), .mode(mode),
        .csr_st(csr_st), .csr_en(csr_en), .csr_pc(csr_pc), .csr_code(csr_code),
        .mip_out(mip_out), .stall_fetch(stall_fetch), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        state_csr    st;
        logic        chk;
        logic [63:0] pc;
        logic [63:0] code;
    } csr_exp_t;

    csr_exp_t    q_csr[$];
    logic [63:0] q_tgt[$];
    int          vectors = 0;
    int          miscompares = 0;

`ifdef TRAP_CTRL_VECTORED_EN
    localparam logic [63:0] VEC_TGT = 64'h8000_002C;
`else
    localparam logic [63:0] VEC_TGT = 64'h8000_0000;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bound_hit(input string name, input int n, input int lim);
        vectors++;
        if (n >= lim) begin
            miscompares++;
            $display("FAIL %s: no progress after %0d cycles", name, n);
        end
    endtask

    // Monitor: compares every CSR command and every accepted redirect.
    always @(negedge clk) begin : monitor
        csr_exp_t    e;
        logic [63:0] t;
        if (rst_n) begin
            if (csr_en) begin
                if (q_csr.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_csr_cmd: got st=%0d, expected none", csr_st);
                end else begin
                    e = q_csr.pop_front();
                    check("csr_st", 64'(csr_st), 64'(e.st));
                    check("commit_flush", 64'(flush), 64'd1);
                    if (e.chk) begin
                        check("csr_pc", csr_pc, e.pc);
                        check("csr_code", csr_code, e.code);
                    end
                end
            end
            if (redirect_valid && redirect_ready) begin
                if (q_tgt.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_redirect: got %h, expected none", redirect_pc);
                end else begin
                    t = q_tgt.pop_front();
                    check("redirect_pc", redirect_pc, t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input state_csr st, input logic chk, input logic [63:0] pc,
                        input logic [63:0] code, input logic push_t, input logic [63:0] tgt);
        csr_exp_t e;
        e.st = st; e.chk = chk; e.pc = pc; e.code = code;
        q_csr.push_back(e);
        if (push_t) q_tgt.push_back(tgt);
    endtask

    task automatic commit_event(input logic exc, input logic mret,
                                input logic [63:0] pc, input logic [63:0] code);
        commit_valid = 1'b1; commit_exc = exc; commit_mret = mret;
        commit_pc = pc; commit_exc_code = code;
        tick();
        commit_valid = 1'b0; commit_exc = 1'b0; commit_mret = 1'b0;
    endtask

    task automatic wait_csr(input string name);
        int n = 0;
        while (q_csr.size() != 0 && n < 50) begin tick(); n++; end
        bound_hit(name, n, 50);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((q_csr.size() != 0 || q_tgt.size() != 0 || stall_fetch) && n < 50) begin
            tick(); n++;
        end
        bound_hit(name, n, 50);
    endtask

    initial begin
        int k;
        #1;
        check("rst_csr_st", 64'(csr_st), 64'(NONE));
        check("rst_csr_en", 64'(csr_en), 64'd0);
        check("rst_stall", 64'(stall_fetch), 64'd0);
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_redirect_pc", redirect_pc, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Synchronous exception, mtvec direct mode.
        push(ERROR, 1'b1, 64'h8000_0010, 64'd2, 1'b1, 64'h8000_0100);
        commit_event(1'b1, 1'b0, 64'h8000_0010, 64'd2);
        check("exc_flush_next_edge", 64'(flush), 64'd1);
        wait_idle("exc_done");

        // Timer interrupt with a three-cycle drain.
        csr_mie = 64'h80; next_pc = 64'h8000_0200; pipe_empty = 1'b0; irq_mti = 1'b1;
        push(ERROR, 1'b1, 64'h8000_0200, 64'h8000_0000_0000_0007, 1'b1, 64'h8000_0100);
        tick();
        check("mip_out_mti", mip_out, 64'h80);
        tick();
        check("mti_stall_1", 64'(stall_fetch), 64'd1);
        tick();
        check("mti_stall_2", 64'(stall_fetch), 64'd1);
        tick();
        check("mti_stall_3", 64'(stall_fetch), 64'd1);
        check("mti_no_early_flush", 64'(flush), 64'd0);
        pipe_empty = 1'b1; irq_mti = 1'b0;
        tick();
        check("mti_drain_flush", 64'(flush), 64'd1);
        csr_mie = '0;
        wait_idle("mti_done");

        // MEI with mtvec in vectored mode.
        csr_mtvec = 64'h8000_0001; csr_mie = 64'h800; next_pc = 64'h8000_0300; irq_mei = 1'b1;
        push(ERROR, 1'b1, 64'h8000_0300, 64'h8000_0000_0000_000B, 1'b1, VEC_TGT);
        tick(); tick();
        wait_csr("mei_commit");
        irq_mei = 1'b0; csr_mie = '0;
        wait_idle("mei_done");
        csr_mtvec = 64'h8000_0100;

        // Simultaneous MTI + MEI: MEI wins.
        csr_mie = 64'h880; next_pc = 64'h8000_0400; irq_mti = 1'b1; irq_mei = 1'b1;
        push(ERROR, 1'b1, 64'h8000_0400, 64'h8000_0000_0000_000B, 1'b1, 64'h8000_0100);
        tick(); tick();
        wait_csr("both_commit");
        irq_mti = 1'b0; irq_mei = 1'b0; csr_mie = '0;
        wait_idle("both_done");

        // MIE clear in M-mode blocks interrupts; dropping to U-mode takes them.
        csr_mstatus_mie = 1'b0; csr_mie = 64'h8; irq_msi = 1'b1; next_pc = 64'h8000_0440;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mie0_no_trap", 64'(stall_fetch), 64'd0);
        end
        push(ERROR, 1'b1, 64'h8000_0440, 64'h8000_0000_0000_0003, 1'b1, 64'h8000_0100);
        mode = 2'd0;
        tick();
        check("umode_trap_taken", 64'(stall_fetch), 64'd1);
        wait_csr("umode_commit");
        irq_msi = 1'b0; csr_mie = '0; mode = 2'd3; csr_mstatus_mie = 1'b1;
        wait_idle("umode_done");

        // Exception preempts a draining interrupt; interrupt follows afterwards.
        csr_mie = 64'h80; irq_mti = 1'b1; pipe_empty = 1'b0; next_pc = 64'h8000_0600;
        push(ERROR, 1'b1, 64'h8000_0300, 64'd5, 1'b1, 64'h8000_0100);
        push(ERROR, 1'b1, 64'h8000_0600, 64'h8000_0000_0000_0007, 1'b1, 64'h8000_0100);
        tick(); tick();
        check("preempt_in_drain", 64'(stall_fetch), 64'd1);
        commit_event(1'b1, 1'b0, 64'h8000_0300, 64'd5);
        pipe_empty = 1'b1;
        wait_csr("preempt_both_commits");
        irq_mti = 1'b0; csr_mie = '0;
        wait_idle("preempt_done");

        // Drain timeout: pipe never empties.
        csr_mie = 64'h80; irq_mti = 1'b1; pipe_empty = 1'b0; next_pc = 64'h8000_0500;
        push(ERROR, 1'b1, 64'h8000_0500, 64'h8000_0000_0000_0007, 1'b1, 64'h8000_0100);
        tick(); tick();
        k = 0;
        while (!flush && k < 400) begin tick(); k++; end
        check("drain_timeout_cycles", 64'(k), 64'd255);
        irq_mti = 1'b0; csr_mie = '0; pipe_empty = 1'b1;
        wait_idle("timeout_done");

        // MRET with a stalled frontend: redirect held stable.
        csr_mepc = 64'h8000_0040; redirect_ready = 1'b0;
        push(MRET, 1'b0, '0, '0, 1'b0, '0);
        commit_event(1'b0, 1'b1, 64'h8000_0700, '0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("mret_hold_valid", 64'(redirect_valid), 64'd1);
            check("mret_hold_pc", redirect_pc, 64'h8000_0040);
            tick();
        end
        q_tgt.push_back(64'h8000_0040);
        redirect_ready = 1'b1;
        wait_idle("mret_done");

        // Reset asserted in REDIRECT clears everything immediately.
        redirect_ready = 1'b0;
        push(MRET, 1'b0, '0, '0, 1'b0, '0);
        commit_event(1'b0, 1'b1, 64'h8000_0710, '0);
        tick();
        check("pre_reset_in_redirect", 64'(redirect_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("arst_redirect_pc", redirect_pc, 64'd0);
        check("arst_stall", 64'(stall_fetch), 64'd0);
        check("arst_csr_pc", csr_pc, 64'd0);
        check("arst_csr_st", 64'(csr_st), 64'(NONE));
        tick();
        rst_n = 1'b1; redirect_ready = 1'b1;
        tick(); tick();
        check("csr_queue_left", 64'(q_csr.size()), 64'd0);
        check("tgt_queue_left", 64'(q_tgt.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
